uart_tx_top: RTL
================

Name: uart_tx_top

Overview:
- UART transmitter; the transmit-side counterpart of the uartRx receiver chain.
- Serializes a parallel word into an asynchronous frame: start bit (0), data LSB first, optional parity, one stop bit (1).
- Clocked at the baud rate, one bit period per clk cycle.
- Sits between the system/FIFO side and the serial line; its output drives the receiver's rx_in directly in loopback benches.

Parameters:
dataWidth, 8, number of data bits per frame (legal 5..9)

Ports:
clk  input  1  baud-rate clock; one serial bit per cycle
rst  input  1  synchronous active-low reset
p_data  input  dataWidth  parallel word to transmit
data_valid  input  1  request strobe; p_data is valid while high
par_en  input  1  1 = insert parity bit after data bits
par_type  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, registered; idles high
busy  output  1  high while a frame is on the line; registered

Interface: one clock, clk; reset rst is synchronous and active-low.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, tx_out=1, busy=0, bit counter=0, shift register=0. Reset overrides all else, including mid-frame: line returns high on that edge and the partial frame is abandoned.
- FSM states: IDLE, START, DATA, PARITY, STOP. tx_out and busy are registered and valid from the edge entering each state.
- IDLE: tx_out=1, busy=0.
  - On posedge with data_valid=1, latch p_data, par_en and par_type into internal registers.
  - Compute parity from latched data: even = ^data, odd = ~^data.
  - Go to START. From this edge: tx_out=0, busy=1.
- data_valid is ignored whenever busy=1. Changes to p_data, par_en or par_type mid-frame have no effect.
- START: one cycle, tx_out=0. Then go to DATA with tx_out=data[0].
- DATA: dataWidth cycles. Bit index counter runs 0..dataWidth-1, with tx_out=data[index]. At index dataWidth-1:
  - go to PARITY if latched par_en=1;
  - otherwise go to STOP.
- PARITY: one cycle, tx_out=parity bit. Then go to STOP.
- STOP: one cycle, tx_out=1, busy=1. Then go to IDLE; busy=0 and tx_out=1 from that edge.
- Frame length on the line:
  - dataWidth+2 cycles without parity (10 at default);
  - dataWidth+3 cycles with parity (11 at default).
- Request handling:
  - The earliest next acceptance is the first posedge in IDLE. Minimum inter-frame gap is therefore one mark (high) cycle.
  - A continuously high data_valid produces frames spaced frame-length+1 cycles apart.
  - data_valid is a level request, not a pulse counter. A held request re-sends the current p_data once per acceptance window. The producer deasserts data_valid on the cycle after busy rises.
- Latency: tx_out falls on the same posedge that samples data_valid=1 in IDLE; busy rises on that same edge.
- No glitches: tx_out comes only from a flop.

Test Plan:
- Reset: hold rst=0 for 3 cycles with data_valid=1 -> tx_out=1 and busy=0 throughout; release -> frame begins on first edge with rst=1.
- No parity, p_data=8'hA5, 1-cycle data_valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); busy high for exactly 10 cycles.
- Even parity (par_en=1, par_type=0), p_data=8'h07 -> bits 0,1,1,1,0,0,0,0,0,1,1 with parity bit 1; 11-cycle frame.
- Odd parity (par_en=1, par_type=1), p_data=8'h03:
  - parity bit = 1, frame 11 cycles;
  - toggling par_type and p_data mid-frame does not change the transmitted bits.
- Back-to-back: data_valid held high, p_data=8'h55 then 8'hAA after first busy rise -> exactly one high cycle between stop and next start; loopback into uartRx_top yields data_valid pulses with 8'h55, then 8'hAA.
- Mid-frame reset:
  - assert rst=0 during data bit 4 -> tx_out=1 and busy=0 on that edge;
  - new request after release -> clean full frame;
  - loopback receiver sees no corrupted valid word.

Source files
------------

// File: rtl/uart_tx_top.sv
// -----------------------------------------------------------------------------
// uart_tx_top
//
// UART transmitter clocked at the baud rate (one serial bit per clk cycle).
// Serializes a parallel word into an asynchronous frame:
//   start bit (0), dataWidth data bits LSB first, optional parity bit,
//   one stop bit (1).
// Both line outputs come straight from flops, so the serial line is glitch
// free and can drive a receiver's rx input directly.
//
// Ports:
//   clk        in   baud-rate clock, one serial bit per cycle
//   rst        in   synchronous active-low reset
//   p_data     in   parallel word to transmit (sampled on acceptance)
//   data_valid in   level request; accepted on a posedge while idle
//   par_en     in   1 = append a parity bit after the data bits
//   par_type   in   0 = even parity, 1 = odd parity
//   tx_out     out  registered serial line, idles high
//   busy       out  registered, high while a frame occupies the line
// -----------------------------------------------------------------------------
module uart_tx_top #(
    parameter int dataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] p_data,
    input  logic                 data_valid,
    input  logic                 par_en,
    input  logic                 par_type,
    output logic                 tx_out,
    output logic                 busy
);

    localparam int CNT_W = $clog2(dataWidth + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(dataWidth - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q,   state_d;
    logic                   tx_q,      tx_d;
    logic                   busy_q,    busy_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [dataWidth-1:0]   shift_q,   shift_d;
    logic                   par_en_q,  par_en_d;
    logic                   par_bit_q, par_bit_d;

    // State and line registers. Reset wins over everything, including a
    // frame in progress: the line returns to mark on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Next-state logic. tx_d is the value the line takes when entering
    // state_d, so every bit appears on the edge that enters its state.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    // Capture the whole request so later input changes
                    // cannot disturb the frame. The parity bit is resolved
                    // here once: even = XOR of data, odd = its complement.
                    shift_d   = p_data;
                    par_en_d  = par_en;
                    par_bit_d = par_type ? ~(^p_data) : (^p_data);
                    tx_d      = 1'b0;
                    state_d   = START;
                end
            end

            START: begin
                // Shift register always holds the not-yet-sent bits in
                // its low end, so bit 0 is the next data bit to drive.
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                state_d = DATA;
            end

            DATA: begin
                if (cnt_q == LAST_IDX) begin
                    if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
            end

            STOP: begin
                // Always pass through IDLE: data_valid is not looked at
                // here, which guarantees one mark cycle between frames.
                tx_d    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule
